demux1x4_unstripe: RTL and testbench

- Receive-side counterpart of the 4:1 byte mux: takes one byte-wide serial stream at full rate and redistributes it onto four byte lanes.
- Slot i of each 4-cycle frame belongs to lane i.
- Outputs a registered parallel word (4 lanes + per-lane valid) once per frame, with a one-cycle strobe.
- Sits after the mux in the PHY loopback/compare bench; its lanes are compared against the original mux inputs.

---
 rtl/demux1x4_unstripe_pkg.sv | 15 +
 rtl/demux1x4_unstripe_if.sv | 26 ++
 rtl/demux1x4_unstripe_slot_phase_cnt.sv | 20 ++
 rtl/demux1x4_unstripe.sv | 82 ++++++++
 tb/tb_demux1x4_unstripe.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/demux1x4_unstripe_pkg.sv
// Shared PHY byte-lane constants and types used by the 4:1 mux and its 1:4 unstripe counterpart.
package demux1x4_unstripe_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int PHASE_W   = 2;

    typedef logic [BYTE_W-1:0]    lane_byte_t;
    typedef logic [NUM_LANES-1:0] lane_valid_t;
    typedef logic [PHASE_W-1:0]   phase_t;

    // Slot index of the byte that completes a frame.
    localparam phase_t LAST_SLOT = phase_t'(NUM_LANES - 1);

endpackage

// File: rtl/demux1x4_unstripe_if.sv
// Serial-in / parallel-out bus of the byte unstriper.
interface demux1x4_unstripe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic [WIDTH-1:0] in;
    logic             valid_in;
    logic             align;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [LANES-1:0] valid_out;
    logic             out_stb;
    logic [1:0]       phase;

    modport master (
        output in, valid_in, align,
        input  out0, out1, out2, out3, valid_out, out_stb, phase
    );

    modport slave (
        input  in, valid_in, align,
        output out0, out1, out2, out3, valid_out, out_stb, phase
    );
endinterface

// File: rtl/demux1x4_unstripe_slot_phase_cnt.sv
// Free-running 2-bit slot counter; align restarts the frame so the next slot is 1.
module demux1x4_unstripe_slot_phase_cnt
    import demux1x4_unstripe_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   align,
    output phase_t phase
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            phase <= '0;
        else if (align)
            phase <= phase_t'(1);
        else
            phase <= phase + phase_t'(1);
    end

endmodule

// File: rtl/demux1x4_unstripe.sv
// 1:4 byte unstriper: slot i of each 4-cycle frame is collected onto lane i, then
// all lanes are presented together with a one-cycle strobe.
module demux1x4_unstripe
    import demux1x4_unstripe_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int LANES = NUM_LANES
)(
    input  logic                 clk,
    input  logic                 reset,
    demux1x4_unstripe_if.slave   bus
);

    phase_t                        phase;
    logic                          frame_end;
    logic [WIDTH-1:0]              cur_byte;
    logic [LANES-2:0][WIDTH-1:0]   coll;
    logic [LANES-2:0]              cvalid;
    logic [LANES-1:0][WIDTH-1:0]   lane_q;
    logic [LANES-1:0]              vld_q;
    logic                          stb_q;

    demux1x4_unstripe_slot_phase_cnt u_phase (
        .clk   (clk),
        .reset (reset),
        .align (bus.align),
        .phase (phase)
    );

    // Invalid slots carry zero so a lane never shows a stale byte.
    assign cur_byte  = bus.valid_in ? bus.in : '0;
    // An align on the last slot suppresses the load: that cycle becomes slot 0.
    assign frame_end = (phase == LAST_SLOT) && !bus.align;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coll   <= '0;
            cvalid <= '0;
        end else begin
            for (int l = 0; l < LANES-1; l++) begin
                if (bus.align) begin
                    coll[l]   <= (l == 0) ? cur_byte : '0;
                    cvalid[l] <= (l == 0) ? bus.valid_in : 1'b0;
                end else if (frame_end) begin
                    coll[l]   <= '0;
                    cvalid[l] <= 1'b0;
                end else if (phase == phase_t'(l)) begin
                    coll[l]   <= cur_byte;
                    cvalid[l] <= bus.valid_in;
                end
            end
        end
    end

    // The last lane bypasses the collect stage and loads straight from the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            vld_q  <= '0;
            stb_q  <= 1'b0;
        end else begin
            stb_q <= frame_end;
            if (frame_end) begin
                for (int l = 0; l < LANES-1; l++) begin
                    lane_q[l] <= coll[l];
                    vld_q[l]  <= cvalid[l];
                end
                lane_q[LANES-1] <= cur_byte;
                vld_q[LANES-1]  <= bus.valid_in;
            end
        end
    end

    assign bus.out0      = lane_q[0];
    assign bus.out1      = lane_q[1];
    assign bus.out2      = lane_q[2];
    assign bus.out3      = lane_q[3];
    assign bus.valid_out = vld_q;
    assign bus.out_stb   = stb_q;
    assign bus.phase     = phase;

endmodule

// File: tb/tb_demux1x4_unstripe.sv
// Bench for demux1x4_unstripe: frame-queue reference model checked every cycle,
// directed literal frames, mux->demux loopback and random align traffic.
module tb_demux1x4_unstripe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    demux1x4_unstripe_if #(.WIDTH(8), .LANES(4)) bus ();

    demux1x4_unstripe #(.WIDTH(8), .LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference: bytes gathered since the frame started; four of them make a frame.
    logic [7:0] qb [4];
    logic       qv [4];
    int         qn = 0;
    logic [7:0] eo [4] = '{default: 8'h00};
    logic [3:0] evo = 4'h0;
    logic       estb = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qn   = 0;
            eo   = '{default: 8'h00};
            evo  = 4'h0;
            estb = 1'b0;
        end else begin
            if (bus.align) qn = 0;
            qb[qn] = bus.valid_in ? bus.in : 8'h00;
            qv[qn] = bus.valid_in;
            qn++;
            estb = 1'b0;
            if (qn == 4 && !bus.align) begin
                for (int i = 0; i < 4; i++) begin
                    eo[i]  = qb[i];
                    evo[i] = qv[i];
                end
                estb = 1'b1;
                qn   = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m.out0", 32'(bus.out0), 32'(eo[0]));
        chk("m.out1", 32'(bus.out1), 32'(eo[1]));
        chk("m.out2", 32'(bus.out2), 32'(eo[2]));
        chk("m.out3", 32'(bus.out3), 32'(eo[3]));
        chk("m.valid_out", 32'(bus.valid_out), 32'(evo));
        chk("m.out_stb", 32'(bus.out_stb), 32'(estb));
        chk("m.phase", 32'(bus.phase), 32'(qn));
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic a);
        bus.valid_in = v;
        bus.in       = d;
        bus.align    = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [3:0] ev);
        chk({nm, ".out0"}, 32'(bus.out0), 32'(e0));
        chk({nm, ".out1"}, 32'(bus.out1), 32'(e1));
        chk({nm, ".out2"}, 32'(bus.out2), 32'(e2));
        chk({nm, ".out3"}, 32'(bus.out3), 32'(e3));
        chk({nm, ".valid_out"}, 32'(bus.valid_out), 32'(ev));
        chk({nm, ".out_stb"}, 32'(bus.out_stb), 32'd1);
        chk({nm, ".phase"}, 32'(bus.phase), 32'd0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".outs"}, {bus.out0, bus.out1, bus.out2, bus.out3}, 32'h0);
        chk({nm, ".valid_out"}, 32'(bus.valid_out), 32'h0);
        chk({nm, ".out_stb"}, 32'(bus.out_stb), 32'h0);
        chk({nm, ".phase"}, 32'(bus.phase), 32'h0);
    endtask

    logic [7:0] b [4];
    logic [3:0] v;
    logic [7:0] ex [4];

    initial begin
        bus.in = 8'h00; bus.valid_in = 1'b0; bus.align = 1'b0;
        #1 reset = 1'b0;
        #2 chk_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Full frame, then strobe must drop on the next slot.
        drive(1, 8'hA0, 0); drive(1, 8'hA1, 0); drive(1, 8'hA2, 0); drive(1, 8'hA3, 0);
        chk_frame("full", 8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b1111);

        drive(1, 8'hFF, 0);
        chk("stb_one_cycle", 32'(bus.out_stb), 32'd0);
        drive(0, 8'h5A, 0); drive(1, 8'hCC, 0); drive(0, 8'h33, 0);
        chk_frame("sparse", 8'hFF, 8'h00, 8'hCC, 8'h00, 4'b0101);

        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 4; s++) drive(1, 8'(f*4 + s), 0);
            chk_frame("b2b", 8'(f*4), 8'(f*4+1), 8'(f*4+2), 8'(f*4+3), 4'b1111);
        end

        drive(0, 8'h00, 0); drive(0, 8'h00, 0); drive(0, 8'h00, 0); drive(0, 8'h00, 0);
        chk_frame("all_invalid", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Align in slot 2: old slot 3 must not load.
        drive(1, 8'h11, 0); drive(1, 8'h22, 0);
        drive(1, 8'h55, 1);
        chk("align.phase", 32'(bus.phase), 32'd1);
        drive(1, 8'h66, 0);
        chk("align.no_stb", 32'(bus.out_stb), 32'd0);
        chk("align.hold_out0", 32'(bus.out0), 32'h00);
        drive(1, 8'h77, 0); drive(1, 8'h88, 0);
        chk_frame("align", 8'h55, 8'h66, 8'h77, 8'h88, 4'b1111);

        // Mid-frame asynchronous reset discards the partial frame.
        drive(1, 8'h12, 0); drive(1, 8'h34, 0);
        #3 reset = 1'b0;
        #1 chk_zero("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1, 8'hB0, 0); drive(0, 8'hB1, 0); drive(1, 8'hB2, 0); drive(1, 8'hB3, 0);
        chk_frame("post_reset", 8'hB0, 8'h00, 8'hB2, 8'hB3, 4'b1101);

        // Loopback through a 4:1 mux model: lanes must reproduce the mux inputs.
        for (int f = 0; f < 1000; f++) begin
            v = 4'($urandom);
            for (int s = 0; s < 4; s++) begin
                b[s]  = 8'($urandom);
                ex[s] = v[s] ? b[s] : 8'h00;
                drive(v[s], v[s] ? b[s] : 8'($urandom), 0);
            end
            chk_frame("loop", ex[0], ex[1], ex[2], ex[3], v);
        end

        // Random traffic with random align pulses, checked by the model only.
        for (int c = 0; c < 600; c++)
            drive(1'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
        drive(0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
